mem_access_unit: RTL and testbench

Memory-stage data-access controller between the EX/MEM register and the MEM/WB register. Takes the ALU-computed address, store data and funct3 of a load/store, runs a req/ready handshake with data memory, and stalls the pipeline while the access is outstanding. Performs byte-lane steering for stores and sign/zero extension for loads. Produces the final load value consumed by MEM/WB as its Read_Data input.

---
 rtl/mem_access_unit.sv | 227 ++++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Memory-stage load/store controller: handshakes with data memory, steers store lanes, extends loads.
// Latency: request registered one cycle after issue; result and op_valid one cycle after dmem_ready (min 2 stall cycles).
// Backpressure: stall holds the upstream pipeline while a request is pending; optional MEM_ACCESS_STATS_EN adds counters.
module mem_access_unit #(
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ip_valid,
    input  logic        ip_MemRead,
    input  logic        ip_MemWrite,
    input  logic [2:0]  ip_funct3,
    input  logic [31:0] ip_alu_Result,
    input  logic [31:0] ip_Store_Data,
    output logic        stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ready,
    output logic [31:0] op_Read_Data,
    output logic        op_valid,
    output logic        op_fault,
`ifdef MEM_ACCESS_STATS_EN
    output logic [31:0] op_load_count,
    output logic [31:0] op_store_count,
    output logic [31:0] op_stall_cycles,
`endif
    output logic        op_timeout
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t      state_q, state_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic [8:0]  wait_inc;
    logic        timeout_hit;

    logic        mem_op, is_load, is_store, legal, legal_op, illegal_op;
    logic [3:0]  st_be;
    logic [31:0] st_wdata;

    logic [1:0]  lat_off_q, lat_off_d;
    logic [2:0]  lat_f3_q, lat_f3_d;
    logic        lat_load_q, lat_load_d;
    logic [31:0] rdata_sh, load_ext;

    logic        req_d, we_d, valid_d, fault_d, timeout_d;
    logic [31:0] addr_d, wdata_d, rd_d;
    logic [3:0]  be_d;

    assign mem_op     = ip_valid & (ip_MemRead | ip_MemWrite);
    assign is_load    = ip_MemRead;
    assign is_store   = ip_MemWrite & ~ip_MemRead;
    assign legal_op   = mem_op & legal;
    assign illegal_op = mem_op & ~legal;

    // Unsigned variants exist only for loads; alignment follows the access size.
    always_comb begin
        legal = 1'b0;
        case (ip_funct3)
            3'b000:  legal = 1'b1;
            3'b100:  legal = is_load;
            3'b001:  legal = ~ip_alu_Result[0];
            3'b101:  legal = is_load & ~ip_alu_Result[0];
            3'b010:  legal = (ip_alu_Result[1:0] == 2'b00);
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        st_be    = 4'b1111;
        st_wdata = ip_Store_Data;
        case (ip_funct3[1:0])
            2'b00: begin
                st_be    = 4'b0001 << ip_alu_Result[1:0];
                st_wdata = {4{ip_Store_Data[7:0]}};
            end
            2'b01: begin
                st_be    = 4'b0011 << {ip_alu_Result[1], 1'b0};
                st_wdata = {2{ip_Store_Data[15:0]}};
            end
            default: begin
                st_be    = 4'b1111;
                st_wdata = ip_Store_Data;
            end
        endcase
    end

    assign rdata_sh = dmem_rdata >> {lat_off_q, 3'b000};

    always_comb begin
        load_ext = rdata_sh;
        case (lat_f3_q)
            3'b000:  load_ext = {{24{rdata_sh[7]}}, rdata_sh[7:0]};
            3'b100:  load_ext = {24'd0, rdata_sh[7:0]};
            3'b001:  load_ext = {{16{rdata_sh[15]}}, rdata_sh[15:0]};
            3'b101:  load_ext = {16'd0, rdata_sh[15:0]};
            default: load_ext = rdata_sh;
        endcase
    end

    assign wait_inc    = {1'b0, wait_cnt_q} + 9'd1;
    assign timeout_hit = (wait_inc == 9'(WAIT_MAX));

    // Gated by reset so the pipeline is released the moment reset asserts.
    assign stall = reset & (((state_q == IDLE) & legal_op) | (state_q == ACCESS));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            wait_cnt_q   <= 8'd0;
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            dmem_addr    <= 32'd0;
            dmem_wdata   <= 32'd0;
            dmem_be      <= 4'd0;
            op_Read_Data <= 32'd0;
            op_valid     <= 1'b0;
            op_fault     <= 1'b0;
            op_timeout   <= 1'b0;
            lat_off_q    <= 2'd0;
            lat_f3_q     <= 3'd0;
            lat_load_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            dmem_req     <= req_d;
            dmem_we      <= we_d;
            dmem_addr    <= addr_d;
            dmem_wdata   <= wdata_d;
            dmem_be      <= be_d;
            op_Read_Data <= rd_d;
            op_valid     <= valid_d;
            op_fault     <= fault_d;
            op_timeout   <= timeout_d;
            lat_off_q    <= lat_off_d;
            lat_f3_q     <= lat_f3_d;
            lat_load_q   <= lat_load_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (legal_op) state_d = ACCESS;
            ACCESS:  if (dmem_ready || timeout_hit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_d      = dmem_req;
        we_d       = dmem_we;
        addr_d     = dmem_addr;
        wdata_d    = dmem_wdata;
        be_d       = dmem_be;
        rd_d       = op_Read_Data;
        valid_d    = 1'b0;
        fault_d    = 1'b0;
        timeout_d  = 1'b0;
        wait_cnt_d = wait_cnt_q;
        lat_off_d  = lat_off_q;
        lat_f3_d   = lat_f3_q;
        lat_load_d = lat_load_q;
        case (state_q)
            IDLE: begin
                if (legal_op) begin
                    req_d      = 1'b1;
                    we_d       = is_store;
                    addr_d     = {ip_alu_Result[31:2], 2'b00};
                    be_d       = is_store ? st_be : 4'b1111;
                    wdata_d    = is_store ? st_wdata : 32'd0;
                    wait_cnt_d = 8'd0;
                    lat_off_d  = ip_alu_Result[1:0];
                    lat_f3_d   = ip_funct3;
                    lat_load_d = is_load;
                end else if (illegal_op) begin
                    fault_d = 1'b1;
                end
            end
            ACCESS: begin
                // A late ready on the last permitted cycle still completes normally.
                if (dmem_ready) begin
                    req_d      = 1'b0;
                    valid_d    = 1'b1;
                    wait_cnt_d = 8'd0;
                    if (lat_load_q) rd_d = load_ext;
                end else if (timeout_hit) begin
                    req_d      = 1'b0;
                    valid_d    = 1'b1;
                    timeout_d  = 1'b1;
                    rd_d       = 32'd0;
                    wait_cnt_d = 8'd0;
                end else begin
                    wait_cnt_d = wait_inc[7:0];
                end
            end
            default: ;
        endcase
    end

`ifdef MEM_ACCESS_STATS_EN
    logic ld_done, st_done;
    assign ld_done = (state_q == ACCESS) & dmem_ready & lat_load_q;
    assign st_done = (state_q == ACCESS) & dmem_ready & ~lat_load_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_load_count   <= 32'd0;
            op_store_count  <= 32'd0;
            op_stall_cycles <= 32'd0;
        end else begin
            if (ld_done && op_load_count != 32'hFFFF_FFFF)
                op_load_count <= op_load_count + 32'd1;
            if (st_done && op_store_count != 32'hFFFF_FFFF)
                op_store_count <= op_store_count + 32'd1;
            if (stall && op_stall_cycles != 32'hFFFF_FFFF)
                op_stall_cycles <= op_stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed load/store/fault/timeout/reset vectors against a transaction-level model.
module tb_mem_access_unit;
    localparam int WM = 15;

    logic        clk = 1'b0;
    logic        reset;
    logic        ip_valid, ip_MemRead, ip_MemWrite;
    logic [2:0]  ip_funct3;
    logic [31:0] ip_alu_Result, ip_Store_Data;
    logic        stall, dmem_req, dmem_we, dmem_ready;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata, op_Read_Data;
    logic [3:0]  dmem_be;
    logic        op_valid, op_fault, op_timeout;

    always #5 clk = ~clk;

    mem_access_unit #(.WAIT_MAX(WM)) dut (
        .clk(clk), .reset(reset),
        .ip_valid(ip_valid), .ip_MemRead(ip_MemRead), .ip_MemWrite(ip_MemWrite),
        .ip_funct3(ip_funct3), .ip_alu_Result(ip_alu_Result), .ip_Store_Data(ip_Store_Data),
        .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_rdata(dmem_rdata),
        .dmem_ready(dmem_ready), .op_Read_Data(op_Read_Data), .op_valid(op_valid),
        .op_fault(op_fault), .op_timeout(op_timeout)
    );

    int n_chk = 0;
    int n_fail = 0;
    int n_timeout_seen = 0;
    logic        chk_en = 1'b0;
    logic        exp_stall, exp_req, exp_we, exp_valid, exp_fault, exp_timeout;
    logic [31:0] exp_addr, exp_wdata, exp_rd;
    logic [3:0]  exp_be;
    logic [31:0] m_rd = 32'd0;
    logic [3:0]  last_be = 4'd0;
    logic [31:0] last_wdata = 32'd0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Access size in bytes from the width field.
    function automatic int sz(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic logic m_legal(input logic rd, input logic [2:0] f3, input logic [31:0] a);
        if (f3[1:0] == 2'b11) return 1'b0;
        if (f3[2] && (!rd || f3[1:0] == 2'b10)) return 1'b0;
        return (a % sz(f3)) == 0;
    endfunction

    function automatic logic [3:0] m_be(input logic rd, input logic [2:0] f3, input logic [31:0] a);
        logic [7:0] m;
        if (rd) return 4'hF;
        m = ((8'd1 << sz(f3)) - 8'd1) << a[1:0];
        return m[3:0];
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] w;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % sz(f3)) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] m_ext(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rdata);
        logic [31:0] v, mask;
        int n;
        n = sz(f3);
        v = rdata >> (8 * a[1:0]);
        if (n == 4) return v;
        mask = (32'd1 << (8 * n)) - 32'd1;
        v = v & mask;
        if (!f3[2] && v[8*n-1]) v = v | ~mask;
        return v;
    endfunction

    always @(negedge clk) begin
        if (dmem_req && dmem_we) begin
            last_be    = dmem_be;
            last_wdata = dmem_wdata;
        end
        if (op_timeout) n_timeout_seen++;
        if (chk_en) begin
            check32("stall", {31'd0, stall}, {31'd0, exp_stall});
            check32("dmem_req", {31'd0, dmem_req}, {31'd0, exp_req});
            check32("op_valid", {31'd0, op_valid}, {31'd0, exp_valid});
            check32("op_fault", {31'd0, op_fault}, {31'd0, exp_fault});
            check32("op_timeout", {31'd0, op_timeout}, {31'd0, exp_timeout});
            check32("op_Read_Data", op_Read_Data, exp_rd);
            if (exp_req) begin
                check32("dmem_we", {31'd0, dmem_we}, {31'd0, exp_we});
                check32("dmem_addr", dmem_addr, exp_addr);
                check32("dmem_be", {28'd0, dmem_be}, {28'd0, exp_be});
                if (exp_we) check32("dmem_wdata", dmem_wdata, exp_wdata);
            end
        end
    end

    // rdy_at: ACCESS cycle (1-based) on which memory answers; 0 means never.
    task automatic run_op(input logic v, input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] d, input int rdy_at,
                          input logic [31:0] rdata);
        logic is_mem, lg, got;
        is_mem = v & (rd | wr);
        lg = is_mem && m_legal(rd, f3, a);
        got = 1'b0;
        @(posedge clk); #1;
        ip_valid = v; ip_MemRead = rd; ip_MemWrite = wr; ip_funct3 = f3;
        ip_alu_Result = a; ip_Store_Data = d; dmem_ready = 1'b0;
        exp_stall = lg; exp_req = 1'b0; exp_valid = 1'b0; exp_fault = 1'b0;
        exp_timeout = 1'b0; exp_rd = m_rd;
        if (is_mem && !lg) begin
            @(posedge clk); #1;
            ip_valid = 1'b0;
            exp_fault = 1'b1;
            exp_stall = 1'b0;
        end else if (lg) begin
            exp_we = !rd;
            exp_addr = {a[31:2], 2'b00};
            exp_be = m_be(rd, f3, a);
            exp_wdata = m_wdata(f3, d);
            for (int k = 1; k <= WM; k++) begin
                @(posedge clk); #1;
                exp_req = 1'b1; exp_stall = 1'b1;
                dmem_rdata = rdata;
                dmem_ready = (k == rdy_at);
                if (k == rdy_at) begin
                    got = 1'b1;
                    break;
                end
            end
            @(posedge clk); #1;
            dmem_ready = 1'b0; dmem_rdata = 32'h5A5A_5A5A;
            exp_req = 1'b0; exp_stall = 1'b0; exp_valid = 1'b1; exp_timeout = !got;
            if (!got) m_rd = 32'd0;
            else if (rd) m_rd = m_ext(f3, a, rdata);
            exp_rd = m_rd;
        end
        @(posedge clk); #1;
        ip_valid = 1'b0;
        exp_stall = 1'b0; exp_req = 1'b0; exp_valid = 1'b0; exp_fault = 1'b0;
        exp_timeout = 1'b0; exp_rd = m_rd;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        ip_valid = 1'b0; ip_MemRead = 1'b0; ip_MemWrite = 1'b0; ip_funct3 = 3'd0;
        ip_alu_Result = 32'd0; ip_Store_Data = 32'd0; dmem_ready = 1'b0; dmem_rdata = 32'd0;
        #12;
        check32("rst_req", {31'd0, dmem_req}, 32'd0);
        check32("rst_be", {28'd0, dmem_be}, 32'd0);
        check32("rst_addr", dmem_addr, 32'd0);
        check32("rst_rd", op_Read_Data, 32'd0);
        check32("rst_flags", {29'd0, op_valid, op_fault, op_timeout}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        exp_stall = 0; exp_req = 0; exp_valid = 0; exp_fault = 0; exp_timeout = 0; exp_rd = 0;
        exp_we = 0; exp_addr = 0; exp_be = 0; exp_wdata = 0;
        chk_en = 1'b1;

        run_op(1, 1, 0, 3'b010, 32'h100, 32'h0, 1, 32'hDEAD_BEEF);
        check32("lw_lit", op_Read_Data, 32'hDEAD_BEEF);
        run_op(1, 1, 0, 3'b000, 32'h203, 32'h0, 1, 32'h80FF_0000);
        check32("lb_lit", op_Read_Data, 32'hFFFF_FF80);
        run_op(1, 1, 0, 3'b100, 32'h203, 32'h0, 2, 32'h80FF_0000);
        check32("lbu_lit", op_Read_Data, 32'h0000_0080);
        run_op(1, 1, 0, 3'b001, 32'h202, 32'h0, 1, 32'h80FF_0000);
        check32("lh_lit", op_Read_Data, 32'hFFFF_80FF);
        run_op(1, 1, 0, 3'b101, 32'h202, 32'h0, 1, 32'h80FF_0000);
        check32("lhu_lit", op_Read_Data, 32'h0000_80FF);

        run_op(1, 0, 1, 3'b000, 32'h41, 32'h1234_56AB, 2, 32'h0);
        check32("sb_be_lit", {28'd0, last_be}, 32'h2);
        check32("sb_wdata_lit", last_wdata, 32'hABAB_ABAB);
        check32("sb_rd_hold", op_Read_Data, 32'h0000_80FF);
        run_op(1, 0, 1, 3'b001, 32'h42, 32'h1234_56AB, 1, 32'h0);
        check32("sh_be_lit", {28'd0, last_be}, 32'hC);
        check32("sh_wdata_lit", last_wdata, 32'h56AB_56AB);
        run_op(1, 0, 1, 3'b010, 32'h44, 32'hCAFE_0001, 1, 32'h0);

        run_op(1, 0, 0, 3'b010, 32'h48, 32'h0, 1, 32'h0);
        run_op(0, 1, 0, 3'b010, 32'h48, 32'h0, 1, 32'h0);
        run_op(1, 1, 0, 3'b010, 32'h102, 32'h0, 1, 32'h0);
        run_op(1, 0, 1, 3'b011, 32'h40, 32'h0, 1, 32'h0);
        run_op(1, 1, 0, 3'b001, 32'h201, 32'h0, 1, 32'h0);
        run_op(1, 0, 1, 3'b100, 32'h40, 32'h0, 1, 32'h0);
        run_op(1, 1, 1, 3'b010, 32'h80, 32'h1111_1111, 1, 32'h7654_3210);
        check32("rdwr_lit", op_Read_Data, 32'h7654_3210);

        run_op(1, 1, 0, 3'b010, 32'h104, 32'h0, 0, 32'hFFFF_FFFF);
        check32("timeout_rd_lit", op_Read_Data, 32'h0);
        check32("timeout_seen", n_timeout_seen, 1);
        run_op(1, 1, 0, 3'b010, 32'h108, 32'h0, WM, 32'h1234_5678);
        check32("late_ready_lit", op_Read_Data, 32'h1234_5678);
        check32("late_no_timeout", n_timeout_seen, 1);

        chk_en = 1'b0;
        @(posedge clk); #1;
        ip_valid = 1; ip_MemRead = 1; ip_MemWrite = 0; ip_funct3 = 3'b010; ip_alu_Result = 32'h300;
        dmem_ready = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check32("rst_mid_stall", {31'd0, stall}, 32'd0);
        check32("rst_mid_req", {31'd0, dmem_req}, 32'd0);
        check32("rst_mid_rd", op_Read_Data, 32'd0);
        m_rd = 32'd0;
        @(posedge clk); #1;
        ip_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        exp_stall = 0; exp_req = 0; exp_valid = 0; exp_fault = 0; exp_timeout = 0; exp_rd = 0;
        chk_en = 1'b1;
        run_op(1, 1, 0, 3'b010, 32'h300, 32'h0, 3, 32'hCAFE_F00D);
        check32("post_rst_lit", op_Read_Data, 32'hCAFE_F00D);

        repeat (2) @(posedge clk);
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
